// File: rtl/layer_seq_pkg.sv
// Shared types and constants for the layer select sequencer.
// Optional stall counter in the top is enabled by LAYER_SEQ_STALL_CNT_EN.
package layer_seq_pkg;

  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned LAYER_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEL_A,
    SEL_B,
    DONE
  } state_e;

  localparam logic SEL_SRC_A = 1'b0;
  localparam logic SEL_SRC_B = 1'b1;

endpackage

// File: rtl/seq_word_counter.sv
// Per-layer word counter: counts accepted tokens and flags the final word
// of the layer against the latched length.
module seq_word_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] len,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Extra bit keeps count+1 from wrapping when len is all ones.
  assign last = (({1'b0, count_q} + (CNT_W + 1)'(1)) == {1'b0, len});

endmodule

// File: rtl/layer_select_sequencer.sv
// Issues the fifo_mux2 select token stream for one forward pass per start.
// Define LAYER_SEQ_STALL_CNT_EN to add the stall_cycles output.
module layer_select_sequencer
  import layer_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned LAYER_W = LAYER_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LAYER_W-1:0] num_layers,
  input  logic [CNT_W-1:0]   a_len,
  input  logic [CNT_W-1:0]   b_len,
  output logic               select,
  output logic               select_valid,
  input  logic               select_ready,
  output logic [LAYER_W-1:0] layer,
  output logic               busy,
  output logic               done
`ifdef LAYER_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);

  state_e             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [LAYER_W-1:0] nl_q, nl_d;
  logic [CNT_W-1:0]   a_len_q, a_len_d;
  logic [CNT_W-1:0]   b_len_q, b_len_d;
  logic               select_q, select_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               hs;
  logic               cnt_clr;
  logic               cnt_last;
  logic [CNT_W-1:0]   cnt_len;
  logic               start_acc;

  assign hs        = valid_q & select_ready;
  assign start_acc = (state_q == IDLE) & start;
  assign cnt_len   = (state_q == SEL_B) ? b_len_q : a_len_q;

  seq_word_counter #(
    .CNT_W (CNT_W)
  ) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (hs),
    .len   (cnt_len),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    nl_d    = nl_q;
    a_len_d = a_len_q;
    b_len_d = b_len_q;
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          nl_d    = num_layers;
          a_len_d = a_len;
          b_len_d = b_len;
          layer_d = '0;
          cnt_clr = 1'b1;
          if (num_layers != '0 && a_len != '0) begin
            state_d = SEL_A;
          end else if (num_layers >= LAYER_W'(2) && b_len != '0) begin
            state_d = SEL_B;
          end else begin
            state_d = DONE;
          end
        end
      end
      SEL_A: begin
        if (hs && cnt_last) begin
          layer_d = LAYER_W'(1);
          cnt_clr = 1'b1;
          state_d = (nl_q >= LAYER_W'(2) && b_len_q != '0) ? SEL_B : DONE;
        end
      end
      SEL_B: begin
        if (hs && cnt_last) begin
          layer_d = layer_q + LAYER_W'(1);
          cnt_clr = 1'b1;
          if (layer_q + LAYER_W'(1) == nl_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave a flop directly.
    valid_d  = (state_d == SEL_A) || (state_d == SEL_B);
    select_d = (state_d == SEL_B) ? SEL_SRC_B : SEL_SRC_A;
    busy_d   = valid_d;
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      nl_q     <= '0;
      a_len_q  <= '0;
      b_len_q  <= '0;
      select_q <= SEL_SRC_A;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      nl_q     <= nl_d;
      a_len_q  <= a_len_d;
      b_len_q  <= b_len_d;
      select_q <= select_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign select       = select_q;
  assign select_valid = valid_q;
  assign layer        = layer_q;
  assign busy         = busy_q;
  assign done         = done_q;

`ifdef LAYER_SEQ_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (valid_q && !select_ready && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_layer_select_sequencer.sv
// Self-checking bench for layer_select_sequencer: directed and random passes
// checked against an expected token list built from the pass rules.
module tb_layer_select_sequencer;

  localparam int CW = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] num_layers;
  logic [CW-1:0] a_len;
  logic [CW-1:0] b_len;
  logic          select;
  logic          select_valid;
  logic          select_ready;
  logic [LW-1:0] layer;
  logic          busy;
  logic          done;
`ifdef LAYER_SEQ_STALL_CNT_EN
  logic [31:0]   stall_cycles;
`endif

  layer_select_sequencer #(
    .CNT_W   (CW),
    .LAYER_W (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_layers   (num_layers),
    .a_len        (a_len),
    .b_len        (b_len),
    .select       (select),
    .select_valid (select_valid),
    .select_ready (select_ready),
    .layer        (layer),
    .busy         (busy),
    .done         (done)
`ifdef LAYER_SEQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic sel;
    int   lay;
  } tok_t;

  tok_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Layer 0 reads a_len words from input a; every further layer reads b_len
  // words from input b. Skipping layer 0 starts the b layers at index 0.
  task automatic build_expected(input int nl, input int a, input int b);
    tok_t t;
    exp_q.delete();
    if (nl >= 1 && a != 0) begin
      for (int i = 0; i < a; i++) begin
        t.sel = 1'b0; t.lay = 0; exp_q.push_back(t);
      end
      if (nl >= 2 && b != 0) begin
        for (int l = 1; l < nl; l++) begin
          for (int i = 0; i < b; i++) begin
            t.sel = 1'b1; t.lay = l; exp_q.push_back(t);
          end
        end
      end
    end else if (nl >= 2 && b != 0) begin
      for (int l = 0; l < nl; l++) begin
        for (int i = 0; i < b; i++) begin
          t.sel = 1'b1; t.lay = l; exp_q.push_back(t);
        end
      end
    end
  endtask

  // mode: 0 ready held high, 1 ready toggling from 1, 2 random ready.
  task automatic run_pass(input int nl, input int a, input int b, input int mode,
                          input bit disturb, output int stalls);
    bit just_fin;
    bit finished;
    bit tog;
    bit r;
    int budget;
    build_expected(nl, a, b);
    stalls   = 0;
    tog      = 1'b1;
    finished = 1'b0;
    budget   = 2000;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(select_valid), 32'd0);
    start        = 1'b1;
    num_layers   = LW'(nl);
    a_len        = CW'(a);
    b_len        = CW'(b);
    select_ready = 1'b0;
    just_fin     = (exp_q.size() == 0);
    while (!finished && budget > 0) begin
      @(negedge clk);
      budget--;
      start = 1'b0;
      if (disturb) begin
        start      = 1'($urandom_range(0, 1));
        num_layers = LW'($urandom_range(0, 15));
        a_len      = CW'($urandom_range(0, 9));
        b_len      = CW'($urandom_range(0, 9));
      end
      chk("done", 32'(done), 32'(just_fin));
      chk("valid", 32'(select_valid), 32'(exp_q.size() != 0));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      if (just_fin) begin
        finished = 1'b1;
        start    = 1'b0;
      end
      just_fin = 1'b0;
      if (select_valid && exp_q.size() != 0) begin
        chk("select", 32'(select), 32'(exp_q[0].sel));
        chk("layer", 32'(layer), 32'(exp_q[0].lay));
        case (mode)
          0:       r = 1'b1;
          1:       begin r = tog; tog = ~tog; end
          default: r = 1'($urandom_range(0, 1));
        endcase
        select_ready = r;
        if (r) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) just_fin = 1'b1;
        end else begin
          stalls++;
        end
      end else begin
        select_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!finished) chk("pass_timeout", 32'd0, 32'd1);
    @(negedge clk);
    start        = 1'b0;
    select_ready = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("valid_after_done", 32'(select_valid), 32'd0);
`ifdef LAYER_SEQ_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, 32'(stalls));
`endif
  endtask

  int s;

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    select_ready = 1'b0;
    num_layers   = '0;
    a_len        = '0;
    b_len        = '0;
    repeat (2) @(negedge clk);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_valid", 32'(select_valid), 32'd0);
    chk("rst_layer", 32'(layer), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef LAYER_SEQ_STALL_CNT_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    rst_n = 1'b1;

    run_pass(3, 4, 2, 0, 1'b0, s);
    run_pass(3, 4, 2, 1, 1'b0, s);
    chk("toggle_stall_count", 32'(s), 32'd7);
    run_pass(1, 3, 5, 0, 1'b0, s);
    run_pass(0, 4, 2, 0, 1'b0, s);
    run_pass(2, 0, 0, 2, 1'b0, s);
    run_pass(4, 3, 2, 2, 1'b1, s);

    // Asynchronous reset in the middle of layer 1 (SEL_B).
    @(negedge clk);
    start = 1'b1; num_layers = LW'(3); a_len = CW'(4); b_len = CW'(2);
    select_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_select", 32'(select), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_select", 32'(select), 32'd0);
    chk("arst_valid", 32'(select_valid), 32'd0);
    chk("arst_layer", 32'(layer), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("arst_no_done", 32'(done), 32'd0);
    select_ready = 1'b0;
    rst_n = 1'b1;
    run_pass(3, 4, 2, 0, 1'b0, s);

    for (int i = 0; i < 8; i++) begin
      run_pass($urandom_range(0, 5), $urandom_range(1, 5), $urandom_range(0, 3),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)), s);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
